// File: rtl/title_attract_ctrl.sv
// Attract-mode sequencer: blinks the PRESS FIRE banner, debounces the fire
// key and runs the start / play / holdoff handshake with the game logic.
module title_attract_ctrl #(
   parameter int unsigned BLINK_FRAMES    = 30,
   parameter int unsigned DEBOUNCE_FRAMES = 2,
   parameter int unsigned HOLDOFF_FRAMES  = 60
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic       fire,
   input  logic       game_over,
   output logic       show_text,
   output logic       start_pulse,
   output logic       game_active,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ATTRACT  = 2'b00,
      STARTING = 2'b01,
      PLAYING  = 2'b10,
      HOLDOFF  = 2'b11
   } state_t;

   localparam logic [7:0] BLINK_C = 8'(BLINK_FRAMES);
   localparam logic [7:0] DEB_C   = 8'(DEBOUNCE_FRAMES);
   localparam logic [7:0] HOLD_C  = 8'(HOLDOFF_FRAMES);

   logic       frame_s1_q, frame_s2_q, frame_prev_q;
   logic       fire_s1_q, fire_s2_q;
   logic       tick_q, tick_d;
   logic [7:0] fire_cnt_q, fire_cnt_d;
   logic       fire_db_q, fire_db_d;
   logic       press_q, press_d;
   state_t     state_q, state_d;
   logic [7:0] blink_cnt_q, blink_cnt_d;
   logic       blink_phase_q, blink_phase_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       show_text_q, show_text_d;
   logic       start_pulse_q, start_pulse_d;
   logic       game_active_q, game_active_d;

   // Bring frame_clk and fire into the Clk domain through two flops each
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_s1_q   <= 1'b0;
         frame_s2_q   <= 1'b0;
         frame_prev_q <= 1'b0;
         fire_s1_q    <= 1'b0;
         fire_s2_q    <= 1'b0;
      end else begin
         frame_s1_q   <= frame_clk;
         frame_s2_q   <= frame_s1_q;
         frame_prev_q <= frame_s2_q;
         fire_s1_q    <= fire;
         fire_s2_q    <= fire_s1_q;
      end
   end

   // Frame tick detection, fire debounce and press edge
   always_comb begin
      tick_d     = frame_s2_q & ~frame_prev_q;
      fire_cnt_d = fire_cnt_q;
      fire_db_d  = fire_db_q;
      if (tick_q) begin
         if (fire_s2_q) begin
            if (fire_cnt_q != DEB_C) begin
               fire_cnt_d = fire_cnt_q + 8'd1;
            end
            fire_db_d = (fire_cnt_d == DEB_C);
         end else begin
            fire_cnt_d = 8'd0;
            fire_db_d  = 1'b0;
         end
      end
      press_d = fire_db_d & ~fire_db_q;
   end

   // Next state, counters and outputs; outputs follow the next state
   always_comb begin
      state_d       = state_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      hold_cnt_d    = hold_cnt_q;
      unique case (state_q)
         ATTRACT: begin
            if (press_q) begin
               state_d = STARTING;
            end else if (tick_q) begin
               if (blink_cnt_q == BLINK_C - 8'd1) begin
                  blink_cnt_d   = 8'd0;
                  blink_phase_d = ~blink_phase_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + 8'd1;
               end
            end
         end
         STARTING: begin
            state_d = PLAYING;
         end
         PLAYING: begin
            if (game_over) begin
               state_d    = HOLDOFF;
               hold_cnt_d = 8'd0;
            end
         end
         HOLDOFF: begin
            if (hold_cnt_q == HOLD_C && !fire_db_q) begin
               state_d       = ATTRACT;
               blink_cnt_d   = 8'd0;
               blink_phase_d = 1'b1;
            end else if (tick_q && hold_cnt_q != HOLD_C) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: state_d = ATTRACT;
      endcase
      show_text_d   = (state_d == ATTRACT) ? blink_phase_d
                                           : (state_d == HOLDOFF);
      start_pulse_d = (state_d == STARTING);
      game_active_d = (state_d == STARTING) || (state_d == PLAYING);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tick_q        <= 1'b0;
         fire_cnt_q    <= 8'd0;
         fire_db_q     <= 1'b0;
         press_q       <= 1'b0;
         state_q       <= ATTRACT;
         blink_cnt_q   <= 8'd0;
         blink_phase_q <= 1'b1;
         hold_cnt_q    <= 8'd0;
         show_text_q   <= 1'b1;
         start_pulse_q <= 1'b0;
         game_active_q <= 1'b0;
      end else begin
         tick_q        <= tick_d;
         fire_cnt_q    <= fire_cnt_d;
         fire_db_q     <= fire_db_d;
         press_q       <= press_d;
         state_q       <= state_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         hold_cnt_q    <= hold_cnt_d;
         show_text_q   <= show_text_d;
         start_pulse_q <= start_pulse_d;
         game_active_q <= game_active_d;
      end
   end

   assign show_text   = show_text_q;
   assign start_pulse = start_pulse_q;
   assign game_active = game_active_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_title_attract_ctrl.sv
// Bench for title_attract_ctrl: frame-level reference model of the
// attract / start / play / holdoff behaviour.
module tb_title_attract_ctrl;

   localparam int BF = 30;
   localparam int DF = 2;
   localparam int HF = 60;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       frame_clk;
   logic       fire;
   logic       game_over;
   logic       show_text;
   logic       start_pulse;
   logic       game_active;
   logic [1:0] state_dbg;

   int vectors = 0;
   int miscompares = 0;

   // model: 0 attract, 2 playing, 3 holdoff (starting is transient)
   int m_st, m_run, m_atk, m_hold;
   bit m_db;

   title_attract_ctrl #(
      .BLINK_FRAMES(BF),
      .DEBOUNCE_FRAMES(DF),
      .HOLDOFF_FRAMES(HF)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .frame_clk(frame_clk),
      .fire(fire),
      .game_over(game_over),
      .show_text(show_text),
      .start_pulse(start_pulse),
      .game_active(game_active),
      .state_dbg(state_dbg)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_run = 0; m_db = 0; m_atk = 0; m_hold = 0;
   endtask

   // one frame of the specified behaviour, applied in event order
   task automatic model_frame(input bit f, input bit g, output int starts);
      bit prev, press;
      starts = 0;
      if (m_st == 2 && g) begin m_st = 3; m_hold = 0; end
      m_run = f ? ((m_run < 255) ? m_run + 1 : 255) : 0;
      prev  = m_db;
      m_db  = (m_run >= DF);
      press = m_db && !prev;
      if (m_st == 0 && !press) m_atk++;
      if (m_st == 3 && m_hold < HF) m_hold++;
      if (m_st == 0 && press) begin
         starts = 1;
         m_st = 2;
      end else if (m_st == 3 && m_hold == HF && !m_db) begin
         m_st = 0;
         m_atk = 0;
      end
      if (m_st == 2 && g) begin m_st = 3; m_hold = 0; end
   endtask

   task automatic frame(input string tag, input bit f, input bit g);
      int sp, exp_sp;
      logic exp_show;
      sp = 0;
      fire = f;
      game_over = g;
      frame_clk = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge Clk);
         if (start_pulse === 1'b1) sp++;
         if (i == 7) frame_clk = 1'b0;
      end
      model_frame(f, g, exp_sp);
      exp_show = (m_st == 0) ? (((m_atk / BF) % 2) == 0) : (m_st == 3);
      check({tag, "_state"}, state_dbg, m_st);
      check({tag, "_show"}, show_text, exp_show);
      check({tag, "_active"}, game_active, m_st == 2);
      check({tag, "_pulses"}, sp, exp_sp);
   endtask

   initial begin
      int found;
      Reset_n = 1'b0;
      frame_clk = 1'b0;
      fire = 1'b0;
      game_over = 1'b0;
      m_reset();
      repeat (3) @(negedge Clk);
      check("rst_show", show_text, 1);
      check("rst_pulse", start_pulse, 0);
      check("rst_active", game_active, 0);
      check("rst_state", state_dbg, 0);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);

      // blink through two half-periods and into the third
      for (int i = 0; i < 65; i++) frame("blink", 1'b0, 1'b0);

      // short press rejected, long press starts a game
      frame("short", 1'b1, 1'b0);
      frame("short", 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) frame("long", 1'b1, 1'b0);
      frame("long", 1'b0, 1'b0);

      // fire toggling while playing, then game over
      for (int i = 0; i < 6; i++) frame("play", i[0], 1'b0);
      frame("gover", 1'b0, 1'b1);

      // holdoff with a press around tick 30
      for (int i = 0; i < 27; i++) frame("hold", 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) frame("hpress", 1'b1, 1'b0);
      for (int i = 0; i < 35; i++) frame("hold", 1'b0, 1'b0);

      // holdoff with fire held past the limit
      frame("st2", 1'b1, 1'b0);
      frame("st2", 1'b1, 1'b0);
      frame("hheld", 1'b1, 1'b1);
      for (int i = 0; i < 64; i++) frame("hheld", 1'b1, 1'b0);
      frame("release", 1'b0, 1'b0);
      frame("repress", 1'b1, 1'b0);
      frame("repress", 1'b1, 1'b0);
      frame("repress", 1'b0, 1'b0);

      // randomized fire and game_over
      for (int i = 0; i < 150; i++) begin
         bit f, g;
         f = ($urandom_range(0, 99) < 60);
         g = (m_st == 2) ? ($urandom_range(0, 7) == 0)
                         : ($urandom_range(0, 3) == 0);
         frame("rand", f, g);
      end

      // return to attract before the reset test
      for (int i = 0; i < 100 && m_st != 0; i++)
         frame("drain", 1'b0, m_st == 2);
      check("drain_done", m_st, 0);

      // async reset while STARTING
      frame("pre_rst", 1'b1, 1'b0);
      fire = 1'b1;
      frame_clk = 1'b1;
      found = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge Clk);
         #2;
         if (start_pulse === 1'b1) begin
            found = 1;
            break;
         end
      end
      check("t6_pulse_seen", found, 1);
      Reset_n = 1'b0;
      #1;
      check("t6_pulse", start_pulse, 0);
      check("t6_state", state_dbg, 0);
      check("t6_show", show_text, 1);
      check("t6_active", game_active, 0);
      @(negedge Clk);
      frame_clk = 1'b0;
      fire = 1'b0;
      repeat (8) @(negedge Clk);
      Reset_n = 1'b1;
      m_reset();
      @(negedge Clk);
      for (int i = 0; i < 5; i++) frame("gover_idle", 1'b0, 1'b1);
      frame("post", 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
